pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline around the EX stage.
- Keeps a shadow copy of the ID/EX, EX/MEM and MEM/WB register-address and control fields.
- Drives the EX forwarding selects (ForwardA/ForwardB).
- Detects load-use hazards and inserts bubbles.
- Flushes IF/ID and ID/EX on an EX-resolved jump or branch.
- Freezes the whole pipeline while data memory is not ready.

Parameters:
REG_AW, 5, register-address width
CNT_W, 16, width of the saturating stall and flush event counters

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous active-high reset
id_valid  in  1  ID stage holds a real instruction
id_rs1  in  REG_AW  ID source 1
id_rs2  in  REG_AW  ID source 2
id_rs1_used  in  1  instruction reads rs1
id_rs2_used  in  1  instruction reads rs2
id_rd  in  REG_AW  ID destination
id_regwrite  in  1  ID instruction writes rd
id_memread  in  1  ID instruction is a load
jump2if  in  1  EX redirect (jump or taken branch)
dmem_req  in  1  MEM-stage access in progress
dmem_ready  in  1  data memory completes this cycle
ForwardA  out  2  EX operand-A select: 00 RD1, 10 EX_MEM, 01 MEM_WB
ForwardB  out  2  EX operand-B select, same encoding
pc_write  out  1  PC register load enable
if_id_write  out  1  IF/ID register load enable
if_id_flush  out  1  clear IF/ID to NOP at next edge
id_ex_bubble  out  1  load NOP into ID/EX at next edge
pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
stall_cause  out  2  registered: 00 none, 01 load-use, 10 mem-wait, 11 flush
stall_cnt  out  CNT_W  saturating count of load-use and mem-wait cycles
flush_cnt  out  CNT_W  saturating count of flush events

Behaviour:
- Reset (async, rst=1):
  - All shadow entries invalid; state RUN; stall_cause=00; counters=0.
  - Outputs during reset: ForwardA=ForwardB=00, pc_write=if_id_write=1, if_id_flush=id_ex_bubble=pipe_freeze=0.
- Shadow stages: EX holds {valid, rs1, rs2, rs1_used, rs2_used, rd, regwrite, memread}; MEM and WB hold {valid, rd, regwrite}.
- Shadow advance:
  - Shadow advances on each edge unless pipe_freeze=1.
  - EX receives the ID fields, or becomes invalid if id_ex_bubble=1.
- Forwarding (combinational from shadow, same cycle):
  - ForwardA=10 if MEM.valid, MEM.regwrite, MEM.rd!=0, MEM.rd==EX.rs1 and EX.rs1_used.
  - Else ForwardA=01 under the same conditions against WB.
  - Else ForwardA=00.
  - EX/MEM wins over MEM/WB when both match. ForwardB is symmetric on rs2. x0 is never forwarded.
- Load-use hazard:
  - Raised when id_valid, EX.valid, EX.memread, EX.rd!=0, and EX.rd matches a used ID source.
  - Response: pc_write=0, if_id_write=0, id_ex_bubble=1, for exactly one cycle; the load then moves to MEM and the hazard clears.
- Flush (jump2if=1 and not frozen):
  - if_id_flush=1, id_ex_bubble=1, pc_write=1.
  - Overrides a simultaneous load-use hazard.
  - flush_cnt increments by 1.
- Mem wait (dmem_req=1 and dmem_ready=0):
  - pipe_freeze=1, pc_write=0, if_id_write=0; if_id_flush=0, id_ex_bubble=0.
  - Highest priority; a pending jump or load-use is re-evaluated once the freeze ends.
  - Forward selects stay stable throughout the freeze.
- Priority: FREEZE > FLUSH > LOADUSE > RUN.
- State register: holds the previous cycle's cause and drives stall_cause. Transitions are evaluated every cycle from the current conditions; any state returns to RUN when no condition holds.
- Counters:
  - stall_cnt increments on each LOADUSE or FREEZE cycle.
  - Both counters saturate at all-ones and never wrap.
- Reset mid-stall or mid-freeze: state returns immediately (asynchronously) to the reset values above.

Decomposition:
- Shared package: forward-select encodings (FWD_RD=00, FWD_EXMEM=10, FWD_MEMWB=01), stall_cause encodings, REG_AW.
- One sub-module: fwd_select. Purely combinational; instantiated twice, for operands A and B.

Test Plan:
- add x5,x1,x2 followed by add x6,x5,x3 -> ForwardA=10 in the second instruction's EX cycle; with one NOP in between -> ForwardA=01.
- lw x6,0(x1) followed by add x7,x6,x6 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; next cycle ForwardA=ForwardB=01; stall_cnt=1.
- Writer with rd=x0, then reader of x0 -> ForwardA=ForwardB=00; no stall.
- jump2if=1 for one cycle while the ID instruction has a load-use hazard -> if_id_flush=1, id_ex_bubble=1, pc_write=1; flush_cnt=1; stall_cnt unchanged; stall_cause=11 on the next cycle.
- dmem_req=1 with dmem_ready low for 3 cycles -> pipe_freeze=1 and pc_write=0 for 3 cycles; forward selects constant; stall_cnt=3; normal advance on the 4th cycle.
- rst asserted mid-freeze -> all outputs at reset values immediately; after release, no forwarding until new writers reach MEM.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_pkg
// Purpose  : Shared encodings for the EX-stage hazard controller
// Revision : 1.0 - initial release
// ============================================================================
package pipe_hazard_ctrl_pkg;

  localparam int REG_AW = 5;

  // EX operand forwarding selects
  localparam logic [1:0] FWD_RD    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Controller state; the encoding doubles as the stall_cause output
  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_LOADUSE = 2'b01,
    ST_MEMWAIT = 2'b10,
    ST_FLUSH   = 2'b11
  } state_e;

endpackage : pipe_hazard_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_fwd_select
// Purpose  : Forward-select for one EX operand; EX/MEM beats MEM/WB, x0 never
//            forwarded
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl_fwd_select #(
  parameter int REG_AW = pipe_hazard_ctrl_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic              ex_rs_used,
  input  logic              mem_valid,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              wb_valid,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  output logic [1:0]        fwd
);
  import pipe_hazard_ctrl_pkg::*;

  // Youngest matching producer wins
  always_comb begin
    fwd = FWD_RD;
    if (ex_rs_used && mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
      fwd = FWD_EXMEM;
    else if (ex_rs_used && wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
      fwd = FWD_MEMWB;
  end

endmodule : pipe_hazard_ctrl_fwd_select
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Forwarding, load-use stall, EX-redirect flush and memory-wait
//            freeze control around the EX stage
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int REG_AW = pipe_hazard_ctrl_pkg::REG_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              jump2if,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        stall_cause,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import pipe_hazard_ctrl_pkg::*;

  // Shadow of ID/EX, EX/MEM and MEM/WB fields
  logic              ex_valid_q, ex_rs1_used_q, ex_rs2_used_q, ex_regwrite_q, ex_memread_q;
  logic [REG_AW-1:0] ex_rs1_q, ex_rs2_q, ex_rd_q;
  logic              mem_valid_q, mem_regwrite_q, wb_valid_q, wb_regwrite_q;
  logic [REG_AW-1:0] mem_rd_q, wb_rd_q;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  logic freeze, flush, load_use, stall_evt;

  // Raw hazard conditions; reset masks the input-driven ones
  always_comb begin
    freeze   = !rst && dmem_req && !dmem_ready;
    flush    = !rst && jump2if && !freeze;
    load_use = id_valid && ex_valid_q && ex_memread_q && (ex_rd_q != '0) &&
               ((id_rs1_used && (id_rs1 == ex_rd_q)) || (id_rs2_used && (id_rs2 == ex_rd_q)));
    stall_evt = freeze || (load_use && !flush);
  end

  // Pipeline control outputs with FREEZE > FLUSH > LOADUSE priority
  always_comb begin
    pipe_freeze  = freeze;
    if_id_flush  = flush;
    id_ex_bubble = !freeze && (flush || load_use);
    pc_write     = !freeze && (flush || !load_use);
    if_id_write  = !freeze && (flush || !load_use);
  end

  // Next cause and saturating event counters
  always_comb begin
    state_d = ST_RUN;
    if (freeze)        state_d = ST_MEMWAIT;
    else if (flush)    state_d = ST_FLUSH;
    else if (load_use) state_d = ST_LOADUSE;
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // Cause register and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Shadow pipeline advance; holds while frozen, bubble invalidates EX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid_q <= 1'b0; ex_rs1_used_q <= 1'b0; ex_rs2_used_q <= 1'b0;
      ex_regwrite_q <= 1'b0; ex_memread_q <= 1'b0;
      ex_rs1_q <= '0; ex_rs2_q <= '0; ex_rd_q <= '0;
      mem_valid_q <= 1'b0; mem_regwrite_q <= 1'b0; mem_rd_q <= '0;
      wb_valid_q <= 1'b0; wb_regwrite_q <= 1'b0; wb_rd_q <= '0;
    end else if (!freeze) begin
      ex_valid_q    <= id_valid && !id_ex_bubble;
      ex_rs1_q      <= id_rs1;
      ex_rs2_q      <= id_rs2;
      ex_rs1_used_q <= id_rs1_used;
      ex_rs2_used_q <= id_rs2_used;
      ex_rd_q       <= id_rd;
      ex_regwrite_q <= id_regwrite;
      ex_memread_q  <= id_memread;
      mem_valid_q    <= ex_valid_q;
      mem_regwrite_q <= ex_regwrite_q;
      mem_rd_q       <= ex_rd_q;
      wb_valid_q     <= mem_valid_q;
      wb_regwrite_q  <= mem_regwrite_q;
      wb_rd_q        <= mem_rd_q;
    end
  end

  pipe_hazard_ctrl_fwd_select #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_rs(ex_rs1_q), .ex_rs_used(ex_rs1_used_q && ex_valid_q),
    .mem_valid(mem_valid_q), .mem_regwrite(mem_regwrite_q), .mem_rd(mem_rd_q),
    .wb_valid(wb_valid_q), .wb_regwrite(wb_regwrite_q), .wb_rd(wb_rd_q),
    .fwd(ForwardA)
  );

  pipe_hazard_ctrl_fwd_select #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_rs(ex_rs2_q), .ex_rs_used(ex_rs2_used_q && ex_valid_q),
    .mem_valid(mem_valid_q), .mem_regwrite(mem_regwrite_q), .mem_rd(mem_rd_q),
    .wb_valid(wb_valid_q), .wb_regwrite(wb_regwrite_q), .wb_rd(wb_rd_q),
    .fwd(ForwardB)
  );

  assign stall_cause = state_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule : pipe_hazard_ctrl
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench for pipe_hazard_ctrl
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_regwrite = 1'b0, id_memread = 1'b0;
  logic        jump2if = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
  logic [1:0]  ForwardA, ForwardB, stall_cause;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze;
  logic [15:0] stall_cnt, flush_cnt;

  int checks = 0;
  int failures = 0;
  int exp_stall = 0;
  int exp_flush = 0;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .jump2if(jump2if), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .ForwardA(ForwardA), .ForwardB(ForwardB),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .pipe_freeze(pipe_freeze),
    .stall_cause(stall_cause), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Advance one clock, land just after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rs1_used = u1; id_rs2_used = u2;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    repeat (3) tick();
  endtask

  task automatic test_reset();
    #2;
    checks++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin failures++; $display("FAIL reset_fwd got=%b/%b exp=00/00", ForwardA, ForwardB); end
    checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== 5'b11000) begin failures++; $display("FAIL reset_ctrl got=%b exp=11000", {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}); end
    checks++; if (stall_cause !== 2'b00 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL reset_state got=%b/%0d/%0d exp=00/0/0", stall_cause, stall_cnt, flush_cnt); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_exmem();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();   // add x5,x1,x2
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); tick();   // add x6,x5,x3
    nop(); #1;
    checks++; if (ForwardA !== 2'b10) begin failures++; $display("FAIL fwd_exmem_A got=%b exp=10", ForwardA); end
    checks++; if (ForwardB !== 2'b00) begin failures++; $display("FAIL fwd_exmem_B got=%b exp=00", ForwardB); end
    drain();
  endtask

  task automatic test_fwd_memwb();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    nop(); tick();
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); tick();
    nop(); #1;
    checks++; if (ForwardA !== 2'b01) begin failures++; $display("FAIL fwd_memwb_A got=%b exp=01", ForwardA); end
    drain();
    // Both producers write x5: the younger (EX/MEM) must win on operand B
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd3, 5'd4, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd3, 5'd5, 1, 1, 5'd6, 1, 0); tick();
    nop(); #1;
    checks++; if (ForwardB !== 2'b10 || ForwardA !== 2'b00) begin failures++; $display("FAIL fwd_priority got=%b/%b exp=00/10", ForwardA, ForwardB); end
    drain();
  endtask

  task automatic test_load_use();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1); tick();   // lw x6,0(x1)
    set_id(1, 5'd6, 5'd6, 1, 1, 5'd7, 1, 0); #1;       // add x7,x6,x6
    checks++; if ({pc_write, if_id_write, id_ex_bubble, if_id_flush} !== 4'b0010) begin failures++; $display("FAIL lu_stall got=%b exp=0010", {pc_write, if_id_write, id_ex_bubble, if_id_flush}); end
    tick(); exp_stall++;
    checks++; if ({pc_write, if_id_write, id_ex_bubble} !== 3'b110) begin failures++; $display("FAIL lu_release got=%b exp=110", {pc_write, if_id_write, id_ex_bubble}); end
    checks++; if (stall_cause !== 2'b01) begin failures++; $display("FAIL lu_cause got=%b exp=01", stall_cause); end
    tick();
    nop(); #1;
    checks++; if (ForwardA !== 2'b01 || ForwardB !== 2'b01) begin failures++; $display("FAIL lu_fwd got=%b/%b exp=01/01", ForwardA, ForwardB); end
    checks++; if (stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL lu_cnt got=%0d exp=%0d", stall_cnt, exp_stall); end
    checks++; if (stall_cause !== 2'b00) begin failures++; $display("FAIL lu_cause_clear got=%b exp=00", stall_cause); end
    drain();
  endtask

  task automatic test_x0();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd0, 1, 0); tick();   // add x0,x1,x2
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1); tick();   // lw x0,0(x1)
    set_id(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0); #1;       // add x7,x0,x0
    checks++; if (pc_write !== 1'b1 || id_ex_bubble !== 1'b0) begin failures++; $display("FAIL x0_nostall got=%b%b exp=10", pc_write, id_ex_bubble); end
    tick();
    nop(); #1;
    checks++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin failures++; $display("FAIL x0_fwd got=%b/%b exp=00/00", ForwardA, ForwardB); end
    drain();
  endtask

  task automatic test_flush();
    set_id(1, 5'd1, 5'd0, 1, 0, 5'd6, 1, 1); tick();
    set_id(1, 5'd6, 5'd6, 1, 1, 5'd7, 1, 0); jump2if = 1'b1; #1;
    checks++; if ({if_id_flush, id_ex_bubble, pc_write, pipe_freeze} !== 4'b1110) begin failures++; $display("FAIL flush_ctrl got=%b exp=1110", {if_id_flush, id_ex_bubble, pc_write, pipe_freeze}); end
    tick(); exp_flush++;
    jump2if = 1'b0; nop(); #1;
    checks++; if (stall_cause !== 2'b11) begin failures++; $display("FAIL flush_cause got=%b exp=11", stall_cause); end
    checks++; if (flush_cnt !== 16'(exp_flush) || stall_cnt !== 16'(exp_stall)) begin failures++; $display("FAIL flush_cnts got=%0d/%0d exp=%0d/%0d", flush_cnt, stall_cnt, exp_flush, exp_stall); end
    drain();
  endtask

  task automatic test_freeze();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); tick();
    nop(); dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      jump2if = (c == 1);
      #1;
      checks++; if ({pipe_freeze, pc_write, if_id_write, if_id_flush, id_ex_bubble} !== 5'b10000) begin failures++; $display("FAIL frz_ctrl cyc=%0d got=%b exp=10000", c, {pipe_freeze, pc_write, if_id_write, if_id_flush, id_ex_bubble}); end
      checks++; if (ForwardA !== 2'b10 || ForwardB !== 2'b00) begin failures++; $display("FAIL frz_fwd cyc=%0d got=%b/%b exp=10/00", c, ForwardA, ForwardB); end
      tick(); exp_stall++;
    end
    jump2if = 1'b0; dmem_ready = 1'b1; #1;
    checks++; if (pipe_freeze !== 1'b0 || pc_write !== 1'b1 || stall_cause !== 2'b10) begin failures++; $display("FAIL frz_end got=%b%b/%b exp=01/10", pipe_freeze, pc_write, stall_cause); end
    checks++; if (stall_cnt !== 16'(exp_stall) || flush_cnt !== 16'(exp_flush)) begin failures++; $display("FAIL frz_cnts got=%0d/%0d exp=%0d/%0d", stall_cnt, flush_cnt, exp_stall, exp_flush); end
    tick();
    dmem_req = 1'b0; dmem_ready = 1'b0; #1;
    checks++; if (ForwardA !== 2'b00 || stall_cause !== 2'b00) begin failures++; $display("FAIL frz_advance got=%b/%b exp=00/00", ForwardA, stall_cause); end
    drain();
  endtask

  task automatic test_reset_mid_freeze();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); tick();
    nop(); dmem_req = 1'b1; dmem_ready = 1'b0; tick();
    #2; rst = 1'b1; #1;
    exp_stall = 0; exp_flush = 0;
    checks++; if ({pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze} !== 5'b11000) begin failures++; $display("FAIL rmid_ctrl got=%b exp=11000", {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze}); end
    checks++; if (ForwardA !== 2'b00 || stall_cause !== 2'b00 || stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin failures++; $display("FAIL rmid_state got=%b/%b/%0d/%0d exp=00/00/0/0", ForwardA, stall_cause, stall_cnt, flush_cnt); end
    tick();
    rst = 1'b0; dmem_req = 1'b0;
    set_id(1, 5'd6, 5'd5, 1, 1, 5'd8, 1, 0); tick();   // reads pre-reset destinations
    nop(); #1;
    checks++; if (ForwardA !== 2'b00 || ForwardB !== 2'b00) begin failures++; $display("FAIL rmid_nofwd got=%b/%b exp=00/00", ForwardA, ForwardB); end
    drain();
    set_id(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0); tick();
    set_id(1, 5'd5, 5'd3, 1, 1, 5'd6, 1, 0); tick();
    nop(); #1;
    checks++; if (ForwardA !== 2'b10) begin failures++; $display("FAIL rmid_refwd got=%b exp=10", ForwardA); end
    drain();
  endtask

  initial begin
    test_reset();
    test_fwd_exmem();
    test_fwd_memwb();
    test_load_use();
    test_x0();
    test_flush();
    test_freeze();
    test_reset_mid_freeze();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Watchdog: guarantees termination
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule : tb_pipe_hazard_ctrl
`default_nettype wire
